mem_port_arbiter: RTL and testbench

Two-requester arbiter for the processor's single-port data/instruction memory. It shares the port between the multicycle CPU datapath and the debug/loader host port, which preloads programs and inspects memory. Every access is sequenced through a fixed four-state transaction: issue, wait for synchronous read data, then acknowledge. The debug port has priority, limited by a starvation guard so the CPU always makes progress.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port memory between the
// CPU datapath and the debug/loader port. Each access runs a fixed
// IDLE -> ISSUE -> WAIT -> DONE sequence. Debug has priority, but a run
// counter hands the port to a waiting CPU after MAX_DBG_RUN debug grants.
module mem_port_arbiter #(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int MAX_DBG_RUN = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int RW = $clog2(MAX_DBG_RUN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] dbg_run_q, dbg_run_d;
  logic          win_dbg_q, win_dbg_d;
  logic          txn_we_q, txn_we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          run_at_max;
  logic          pick_dbg;

  // Next-state, arbitration and registered-output decode
  always_comb begin
    state_d     = state_q;
    dbg_run_d   = dbg_run_q;
    win_dbg_d   = win_dbg_q;
    txn_we_d    = txn_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    run_at_max  = (dbg_run_q == RW'(MAX_DBG_RUN));
    // Debug wins unless the CPU is waiting and debug has used up its run
    pick_dbg    = dbg_req && !(cpu_req && run_at_max);

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d     = S_ISSUE;
          win_dbg_d   = pick_dbg;
          txn_we_d    = pick_dbg ? dbg_we : cpu_we;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_dbg ? dbg_we : cpu_we;
          mem_addr_d  = pick_dbg ? dbg_addr : cpu_addr;
          mem_wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
          // Count only debug grants that made a pending CPU wait
          if (pick_dbg && cpu_req) begin
            dbg_run_d = run_at_max ? dbg_run_q : dbg_run_q + RW'(1);
          end else begin
            dbg_run_d = '0;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d   = S_DONE;
        cpu_ack_d = !win_dbg_q;
        dbg_ack_d = win_dbg_q;
        if (!txn_we_q) begin
          if (win_dbg_q) dbg_rdata_d = mem_rdata;
          else           cpu_rdata_d = mem_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dbg_run_q   <= '0;
      win_dbg_q   <= 1'b0;
      txn_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dbg_run_q   <= dbg_run_d;
      win_dbg_q   <= win_dbg_d;
      txn_we_q    <= txn_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a small synchronous RAM on the memory side and
// a transaction-level reference (grant timestamps plus a shadow memory)
// that predicts every output each cycle.
module tb_mem_port_arbiter;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int MAXR = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_ack, dbg_ack;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.DW(DW), .AW(AW), .MAX_DBG_RUN(MAXR)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory attached to the arbiter: synchronous write, registered read
  logic [DW-1:0] ram [0:255];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the last grant's edge index and contents, plus shadow memory
  int            cyc = 0;
  int            g_cyc = 0;
  bit            have_g = 0;
  bit            g_dbg, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, g_rval;
  int            run = 0;
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_crd = '0, exp_drd = '0;
  bit            cpu_ack_seen, dbg_ack_seen;

  task automatic model_reset();
    have_g = 0; run = 0; exp_crd = '0; exp_drd = '0;
  endtask

  // Predict the coming edge from the current inputs, advance one cycle, compare
  task automatic step();
    bit pick;
    int d;
    if ((!have_g || cyc >= g_cyc + 4) && (cpu_req || dbg_req)) begin
      pick = dbg_req && !(cpu_req && run == MAXR);
      if (pick && cpu_req) run = (run < MAXR) ? run + 1 : MAXR;
      else                 run = 0;
      have_g  = 1;
      g_cyc   = cyc;
      g_dbg   = pick;
      g_we    = pick ? dbg_we : cpu_we;
      g_addr  = pick ? dbg_addr : cpu_addr;
      g_wdata = pick ? dbg_wdata : cpu_wdata;
      if (g_we) ref_mem[g_addr[7:0]] = g_wdata;
      else      g_rval = ref_mem[g_addr[7:0]];
    end
    if (have_g && cyc == g_cyc + 2 && !g_we) begin
      if (g_dbg) exp_drd = g_rval;
      else       exp_crd = g_rval;
    end
    @(posedge CLK); #1;
    d = have_g ? cyc - g_cyc : -1;
    check("mem_en",    {31'd0, mem_en},  {31'd0, d == 0});
    check("mem_we",    {31'd0, mem_we},  {31'd0, d == 0 && g_we});
    check("mem_addr",  {16'd0, mem_addr},  have_g ? {16'd0, g_addr}  : 32'd0);
    check("mem_wdata", {16'd0, mem_wdata}, have_g ? {16'd0, g_wdata} : 32'd0);
    check("cpu_ack",   {31'd0, cpu_ack}, {31'd0, d == 2 && !g_dbg});
    check("dbg_ack",   {31'd0, dbg_ack}, {31'd0, d == 2 && g_dbg});
    check("busy",      {31'd0, busy},    {31'd0, d >= 0 && d <= 2});
    check("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, exp_crd});
    check("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, exp_drd});
    cpu_ack_seen = cpu_ack;
    dbg_ack_seen = dbg_ack;
    cyc++;
  endtask

  // One complete access on a single port; req released once its ack is seen
  task automatic do_txn(input bit is_dbg, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    bit done = 0;
    int n = 0;
    rd = '0;
    if (is_dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else        begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    while (!done && n < 20) begin
      step();
      n++;
      if (is_dbg ? dbg_ack_seen : cpu_ack_seen) begin
        done = 1;
        rd = is_dbg ? dbg_rdata : cpu_rdata;
      end
    end
    if (is_dbg) dbg_req = 0; else cpu_req = 0;
    if (!done) check("txn_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int acks, pulses;
    bit order_q[$];

    reset = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    #12;
    check("rst_mem_en",    {31'd0, mem_en}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_cpu_ack",   {31'd0, cpu_ack}, 32'd0);
    check("rst_dbg_ack",   {31'd0, dbg_ack}, 32'd0);
    check("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
    check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    check("rst_dbg_rdata", {16'd0, dbg_rdata}, 32'd0);
    @(negedge CLK);
    reset = 0;
    model_reset();

    // Loader preloads addresses 0..15 through the debug port
    for (int i = 0; i < 16; i++)
      do_txn(1, 1, AW'(i), (i == 5) ? 16'h0063 : DW'($urandom), rd);

    // CPU read of a preloaded word
    do_txn(0, 0, 16'h0005, 16'h0000, rd);
    check("cpu_read_5", {16'd0, rd}, 32'h0063);

    // Debug write then CPU read of the same word
    do_txn(1, 1, 16'h0010, 16'hBEEF, rd);
    do_txn(0, 0, 16'h0010, 16'h0000, rd);
    check("cpu_read_beef", {16'd0, rd}, 32'hBEEF);
    step(); step();

    // Contention: both held; expect four debug grants then one CPU grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0004;
    for (int i = 0; i < 24; i++) begin
      step();
      if (dbg_ack_seen) order_q.push_back(1'b1);
      if (cpu_ack_seen) order_q.push_back(1'b0);
    end
    check("contend_acks", order_q.size(), 32'd6);
    for (int i = 0; i < order_q.size(); i++)
      check("contend_order", {31'd0, order_q[i]}, (i % 5 == 4) ? 32'd0 : 32'd1);
    cpu_req = 0; dbg_req = 0;
    for (int i = 0; i < 4; i++) step();

    // Reset during WAIT of a CPU read aborts without an ack
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002;
    step(); step();
    cpu_req = 0;
    #1 reset = 1;
    #1;
    check("abort_mem_en",    {31'd0, mem_en}, 32'd0);
    check("abort_busy",      {31'd0, busy}, 32'd0);
    check("abort_mem_addr",  {16'd0, mem_addr}, 32'd0);
    check("abort_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    check("abort_dbg_rdata", {16'd0, dbg_rdata}, 32'd0);
    @(posedge CLK); #1;
    check("abort_no_ack", {31'd0, cpu_ack}, 32'd0);
    reset = 0;
    model_reset();
    cyc++;
    do_txn(1, 0, 16'h0005, 16'h0000, rd);
    check("dbg_read_after_rst", {16'd0, rd}, 32'h0063);
    step(); step();

    // Early drop in WAIT still completes with one ack
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0009;
    step(); step();
    cpu_req = 0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cpu_ack_seen) acks++;
    end
    check("early_drop_acks", acks, 32'd1);

    // Held request: a new access every 4 cycles, none in the DONE cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0007;
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (mem_en) pulses++;
    end
    check("held_pulses", pulses, 32'd4);
    cpu_req = 0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic on both ports
    for (int i = 0; i < 3000; i++) begin
      step();
      if (cpu_req) begin
        if (cpu_ack_seen) begin
          if ($urandom_range(3) != 0) cpu_req = 0;
        end else if ($urandom_range(31) == 0) cpu_req = 0;
      end else if ($urandom_range(2) == 0) begin
        cpu_req = 1; cpu_we = $urandom_range(1) == 1;
        cpu_addr = AW'($urandom_range(15)); cpu_wdata = DW'($urandom);
      end
      if (dbg_req) begin
        if (dbg_ack_seen) begin
          if ($urandom_range(3) != 0) dbg_req = 0;
        end else if ($urandom_range(31) == 0) dbg_req = 0;
      end else if ($urandom_range(2) == 0) begin
        dbg_req = 1; dbg_we = $urandom_range(1) == 1;
        dbg_addr = AW'($urandom_range(15)); dbg_wdata = DW'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
